ym_mix_accum: RTL and testbench
===============================

# ym_mix_accum

Parametrised stereo mix accumulator for the time-multiplexed channel DAC output of the OPN-family cores. It sums NUM_CH per-channel offset-binary samples with per-channel panning into one signed stereo sample per frame. Each stereo sample is scaled and saturated or wrapped to OUT_W bits. Results are buffered in a DEPTH-entry FIFO behind a valid/ready handshake. It generalises the fixed 9-bit MOL/MOR pan-mux output stage, which holds one channel at a time, to a summed, buffered, width- and channel-count-configurable output.

## Interface
- NUM_CH, 6, channels per frame (2..16)
- IN_W, 9, input sample width, offset binary (midpoint 2^(IN_W-1) = silence)
- OUT_W, 16, output sample width, two's complement
- GAIN_SH, 5, left shift applied to each frame sum before range reduction
- DEPTH, 4, FIFO entries (power of two, >=2)

- MCLK  in  1  clock; all state changes on rising edge
- IC  in  1  reset, asynchronous, active-low; clears all state
- in_valid  in  1  channel sample present this cycle (no back-pressure on input)
- in_ch  in  clog2(NUM_CH)  channel index of in_data
- in_data  in  IN_W  channel sample, offset binary
- in_pan  in  2  bit1 = route to L, bit0 = route to R
- sat_en  in  1  1: saturate to OUT_W; 0: keep low OUT_W bits (wrap)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_l, out_r  out  OUT_W  FIFO head; 0 when out_valid=0
- frame_err  out  1  one-cycle pulse on channel-sequence violation
- ovf_cnt  out  8  dropped-frame counter, saturating at 255

## Operation
- Sample conversion: s = in_data with MSB inverted, read as signed IN_W. Example: 0x100 -> 0, 0x1FF -> +255, 0x000 -> -256.
- Pan: s_L = in_pan[1] ? s : 0. s_R = in_pan[0] ? s : 0.
- Accumulators acc_l and acc_r are signed, width ACC_W = IN_W + clog2(NUM_CH). Overflow inside the accumulator is impossible.
- Sequencer states:
  - IDLE (waiting for ch 0)
  - ACC (expecting channel exp, 1..NUM_CH-1)
- IDLE transitions:
  - in_valid & in_ch==0: acc = s_x, exp = 1, go to ACC.
  - Other in_valid: discard the sample, pulse frame_err, stay in IDLE.
- ACC transitions:
  - in_valid & in_ch==exp: acc += s_x, exp += 1.
  - in_ch==exp==NUM_CH-1: close the frame and go to IDLE.
  - in_valid & in_ch!=exp: pulse frame_err and abandon the partial frame. If in_ch==0, restart the frame with this sample (stay in ACC, exp = 1); otherwise go to IDLE.
- Frame close:
  - f = (acc + s_x) << GAIN_SH, sign-extended.
  - If sat_en, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; else truncate to the low OUT_W bits.
  - sat_en is sampled in the closing cycle only.
- Push: the closed frame is written to the FIFO if it is not full, or if it is full and a pop occurs in the same cycle. Otherwise the frame is dropped and ovf_cnt increments (sticky at 255).
- Pop: out_valid & out_ready. Ordering is strict FIFO. Simultaneous push and pop at any fill level leaves the count unchanged.
- The FIFO pointers are wrap-around, clog2(DEPTH)+1 bits, so full and empty are distinguishable.

## Timing
- Reset (IC low, asynchronous):
  - out_valid, out_l, out_r, frame_err, ovf_cnt = 0.
  - FIFO empty, sequencer IDLE, accumulators 0.
  - A frame in progress is lost. The first frame after release must start at ch 0.
- Latency: frame closes on edge N; out_valid=1 and the head data are valid after edge N when the FIFO was empty. This is 1 cycle from the last-channel strobe.
- out_l/out_r are stable while out_valid & !out_ready.
- frame_err is high for exactly the cycle after the offending edge; it is registered.
- The input may have gaps (in_valid=0) of any length mid-frame. The sequence state holds.
- Back-to-back frames (NUM_CH consecutive valid cycles each) are sustained with out_ready held high. Throughput is one output per frame.

## Test plan
- Defaults, sat_en=1, all channels 0x1FF, pan 11, out_ready=1 -> out_l=out_r=32767 one cycle after ch5. Same with sat_en=0 -> -16576 (48960 wrapped).
- All channels 0x000, pan 11, sat_en=1 -> -32768 both sides. All channels 0x100 -> 0 both sides.
- ch0 = 0x180 with pan 10, ch1..5 = 0x100 -> out_l=4096, out_r=0. Same with ch0 pan 01 -> out_l=0, out_r=4096.
- Sequence ch0, ch1, ch3 -> frame_err pulse, no output, sequencer back to IDLE. The next full frame is output correctly. A stray ch2 while IDLE -> frame_err, sample discarded.
- out_ready=0 for 6 complete frames (DEPTH=4) -> 4 entries held in order, ovf_cnt=2. Then out_ready=1 -> the 4 entries pop in order and out_valid drops.
- Assert IC mid-frame with the FIFO holding 2 entries -> out_valid=0 and ovf_cnt=0 immediately, without waiting for a clock edge. After release, a ch1-first input yields frame_err and no output.

Source files
------------

// File: rtl/ym_mix_accum_if.sv
// Channel-sample input bus and buffered stereo output bus of the mix accumulator.
// The master drives channel samples and out_ready; the slave (the accumulator) drives the output head.
interface ym_mix_accum_if #(
    parameter int NUM_CH = 6,
    parameter int IN_W   = 9,
    parameter int OUT_W  = 16
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_pan;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_l;
    logic [OUT_W-1:0]  out_r;

    modport master (
        output in_valid, in_ch, in_data, in_pan, out_ready,
        input  out_valid, out_l, out_r
    );

    modport slave (
        input  in_valid, in_ch, in_data, in_pan, out_ready,
        output out_valid, out_l, out_r
    );
endinterface

// File: rtl/ym_mix_accum.sv
// Stereo mix accumulator: sums NUM_CH panned offset-binary channel samples per frame,
// scales and range-reduces each frame, and buffers results in a DEPTH-entry FIFO.
module ym_mix_accum #(
    parameter int NUM_CH  = 6,
    parameter int IN_W    = 9,
    parameter int OUT_W   = 16,
    parameter int GAIN_SH = 5,
    parameter int DEPTH   = 4
) (
    input  logic          MCLK,
    input  logic          IC,
    ym_mix_accum_if.slave bus,
    input  logic          sat_en,
    output logic          frame_err,
    output logic [7:0]    ovf_cnt
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ACC_W  = IN_W + CH_W;
    localparam int FULL_W = ACC_W + GAIN_SH;
    localparam int WIDE_W = ((FULL_W > OUT_W) ? FULL_W : OUT_W) + 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;

    localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } seq_state_t;

    // Out-of-range values clamp to the nearest OUT_W limit when saturating, else keep the low bits.
    function automatic logic [OUT_W-1:0] range_reduce(input logic [WIDE_W-1:0] v, input logic sat);
        logic fits;
        logic [OUT_W-1:0] res;
        fits = (&v[WIDE_W-1:OUT_W-1]) | ~(|v[WIDE_W-1:OUT_W-1]);
        if (!sat || fits) begin
            res = v[OUT_W-1:0];
        end else if (v[WIDE_W-1]) begin
            res = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            res = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return res;
    endfunction

    seq_state_t              state_r;
    logic [CH_W-1:0]         exp_r;
    logic signed [ACC_W-1:0] acc_l_r;
    logic signed [ACC_W-1:0] acc_r_r;
    logic                    frame_err_r;
    logic [7:0]              ovf_cnt_r;

    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [OUT_W-1:0]        mem_l_r [DEPTH];
    logic [OUT_W-1:0]        mem_r_r [DEPTH];
    logic                    out_valid_r;
    logic [OUT_W-1:0]        out_l_r;
    logic [OUT_W-1:0]        out_r_r;

    logic [IN_W-1:0]         samp_s;
    logic signed [ACC_W-1:0] samp_ext_s;
    logic signed [ACC_W-1:0] s_l_s;
    logic signed [ACC_W-1:0] s_r_s;
    logic                    ch_first_s;
    logic                    ch_hit_s;
    logic                    close_s;
    logic                    err_s;
    logic signed [ACC_W-1:0] sum_l_s;
    logic signed [ACC_W-1:0] sum_r_s;
    logic [WIDE_W-1:0]       wide_l_s;
    logic [WIDE_W-1:0]       wide_r_s;
    logic [OUT_W-1:0]        frame_l_s;
    logic [OUT_W-1:0]        frame_r_s;

    logic [PTR_W-1:0]        count_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic [PTR_W-1:0]        rd_nx_s;
    logic [PTR_W-1:0]        wr_nx_s;
    logic [PTR_W-1:0]        cnt_nx_s;
    logic                    bypass_s;
    logic [OUT_W-1:0]        head_l_s;
    logic [OUT_W-1:0]        head_r_s;

    // Offset-binary to signed conversion (MSB flip) and pan routing.
    always_comb begin
        samp_s     = {~bus.in_data[IN_W-1], bus.in_data[IN_W-2:0]};
        samp_ext_s = {{CH_W{samp_s[IN_W-1]}}, samp_s};
        if (bus.in_pan[1]) begin
            s_l_s = samp_ext_s;
        end else begin
            s_l_s = {ACC_W{1'b0}};
        end
        if (bus.in_pan[0]) begin
            s_r_s = samp_ext_s;
        end else begin
            s_r_s = {ACC_W{1'b0}};
        end
    end

    // Channel-sequence decode and closing-frame arithmetic.
    always_comb begin
        ch_first_s = (bus.in_ch == CH_ZERO);
        ch_hit_s   = (bus.in_ch == exp_r);
        close_s    = bus.in_valid & (state_r == ST_ACC) & ch_hit_s & (exp_r == CH_LAST);
        if (state_r == ST_IDLE) begin
            err_s = bus.in_valid & ~ch_first_s;
        end else begin
            err_s = bus.in_valid & ~ch_hit_s;
        end
        sum_l_s   = acc_l_r + s_l_s;
        sum_r_s   = acc_r_r + s_r_s;
        wide_l_s  = {{(WIDE_W-ACC_W){sum_l_s[ACC_W-1]}}, sum_l_s} << GAIN_SH;
        wide_r_s  = {{(WIDE_W-ACC_W){sum_r_s[ACC_W-1]}}, sum_r_s} << GAIN_SH;
        frame_l_s = range_reduce(wide_l_s, sat_en);
        frame_r_s = range_reduce(wide_r_s, sat_en);
    end

    // Frame sequencer: tracks the expected channel and accumulates the partial frame.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            state_r     <= ST_IDLE;
            exp_r       <= CH_ZERO;
            acc_l_r     <= {ACC_W{1'b0}};
            acc_r_r     <= {ACC_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= err_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && ch_first_s) begin
                        acc_l_r <= s_l_s;
                        acc_r_r <= s_r_s;
                        exp_r   <= CH_ONE;
                        state_r <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (bus.in_valid) begin
                        if (ch_hit_s && (exp_r == CH_LAST)) begin
                            acc_l_r <= {ACC_W{1'b0}};
                            acc_r_r <= {ACC_W{1'b0}};
                            exp_r   <= CH_ZERO;
                            state_r <= ST_IDLE;
                        end else if (ch_hit_s) begin
                            acc_l_r <= sum_l_s;
                            acc_r_r <= sum_r_s;
                            exp_r   <= exp_r + CH_ONE;
                        end else if (ch_first_s) begin
                            // A fresh channel 0 restarts the frame rather than waiting for the next one.
                            acc_l_r <= s_l_s;
                            acc_r_r <= s_r_s;
                            exp_r   <= CH_ONE;
                        end else begin
                            acc_l_r <= {ACC_W{1'b0}};
                            acc_r_r <= {ACC_W{1'b0}};
                            exp_r   <= CH_ZERO;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    acc_l_r <= {ACC_W{1'b0}};
                    acc_r_r <= {ACC_W{1'b0}};
                    exp_r   <= CH_ZERO;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO control and the next-cycle head value, so the output can be registered.
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        full_s  = (count_s == PTR_FULL);
        pop_s   = out_valid_r & bus.out_ready;
        push_s  = close_s & (~full_s | pop_s);
        drop_s  = close_s & ~push_s;
        if (pop_s) begin
            rd_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nx_s = rd_ptr_r;
        end
        if (push_s) begin
            wr_nx_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_nx_s = wr_ptr_r;
        end
        cnt_nx_s = wr_nx_s - rd_nx_s;
        // The new head is the frame being written this cycle when nothing older survives the pop.
        if (pop_s) begin
            bypass_s = push_s & (count_s == PTR_ONE);
        end else begin
            bypass_s = push_s & (count_s == PTR_ZERO);
        end
        if (cnt_nx_s == PTR_ZERO) begin
            head_l_s = {OUT_W{1'b0}};
            head_r_s = {OUT_W{1'b0}};
        end else if (bypass_s) begin
            head_l_s = frame_l_s;
            head_r_s = frame_r_s;
        end else begin
            head_l_s = mem_l_r[rd_nx_s[AW-1:0]];
            head_r_s = mem_r_r[rd_nx_s[AW-1:0]];
        end
    end

    // FIFO storage.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_l_r[i] <= {OUT_W{1'b0}};
                mem_r_r[i] <= {OUT_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_l_r[wr_ptr_r[AW-1:0]] <= frame_l_s;
                mem_r_r[wr_ptr_r[AW-1:0]] <= frame_r_s;
            end
        end
    end

    // FIFO pointers, registered head/valid and the saturating dropped-frame counter.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            out_valid_r <= 1'b0;
            out_l_r     <= {OUT_W{1'b0}};
            out_r_r     <= {OUT_W{1'b0}};
            ovf_cnt_r   <= 8'd0;
        end else begin
            wr_ptr_r    <= wr_nx_s;
            rd_ptr_r    <= rd_nx_s;
            out_valid_r <= (cnt_nx_s != PTR_ZERO);
            out_l_r     <= head_l_s;
            out_r_r     <= head_r_s;
            if (drop_s && (ovf_cnt_r != 8'hFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 8'd1;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_l     = out_l_r;
    assign bus.out_r     = out_r_r;
    assign frame_err     = frame_err_r;
    assign ovf_cnt       = ovf_cnt_r;
endmodule

// File: tb/tb_ym_mix_accum.sv
// Self-checking bench for ym_mix_accum: directed scenarios plus randomized traffic,
// all compared every cycle against a frame-level reference model.
module tb_ym_mix_accum;
    localparam int NUM_CH  = 6;
    localparam int IN_W    = 9;
    localparam int OUT_W   = 16;
    localparam int GAIN_SH = 5;
    localparam int DEPTH   = 4;
    localparam int CH_W    = $clog2(NUM_CH);

    logic       MCLK = 1'b0;
    logic       IC   = 1'b0;
    logic       sat_en;
    logic       frame_err;
    logic [7:0] ovf_cnt;

    ym_mix_accum_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    ym_mix_accum #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_SH(GAIN_SH), .DEPTH(DEPTH)
    ) dut (
        .MCLK(MCLK),
        .IC(IC),
        .bus(bus),
        .sat_en(sat_en),
        .frame_err(frame_err),
        .ovf_cnt(ovf_cnt)
    );

    always #5 MCLK = ~MCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents, channels gathered so far, running sums.
    logic [OUT_W-1:0] q_l[$];
    logic [OUT_W-1:0] q_r[$];
    int   got_m;
    int   sum_l_m;
    int   sum_r_m;
    int   ovf_m;
    logic err_m;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] scale_m(input int sum, input logic sat);
        int f;
        f = sum * (1 << GAIN_SH);
        if (sat && (f > (1 << (OUT_W-1)) - 1)) f = (1 << (OUT_W-1)) - 1;
        if (sat && (f < -(1 << (OUT_W-1))))    f = -(1 << (OUT_W-1));
        return f[OUT_W-1:0];
    endfunction

    task automatic model_reset();
        q_l.delete();
        q_r.delete();
        got_m = 0; sum_l_m = 0; sum_r_m = 0; ovf_m = 0; err_m = 1'b0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge(input logic v, input int ch, input logic [IN_W-1:0] d, input logic [1:0] pan);
        int s, sl, sr;
        logic pop, close;
        logic [OUT_W-1:0] fl, fr;
        s  = int'(d) - (1 << (IN_W-1));
        sl = pan[1] ? s : 0;
        sr = pan[0] ? s : 0;
        pop   = (q_l.size() > 0) && bus.out_ready;
        close = 1'b0;
        fl = '0; fr = '0;
        err_m = 1'b0;
        if (v) begin
            if (ch == got_m) begin
                sum_l_m += sl; sum_r_m += sr; got_m++;
                if (got_m == NUM_CH) begin
                    close = 1'b1;
                    fl = scale_m(sum_l_m, sat_en);
                    fr = scale_m(sum_r_m, sat_en);
                    got_m = 0; sum_l_m = 0; sum_r_m = 0;
                end
            end else begin
                err_m = 1'b1;
                if (ch == 0) begin
                    sum_l_m = sl; sum_r_m = sr; got_m = 1;
                end else begin
                    sum_l_m = 0; sum_r_m = 0; got_m = 0;
                end
            end
        end
        if (pop) begin
            void'(q_l.pop_front());
            void'(q_r.pop_front());
        end
        if (close) begin
            if (q_l.size() < DEPTH) begin
                q_l.push_back(fl);
                q_r.push_back(fr);
            end else if (ovf_m < 255) begin
                ovf_m++;
            end
        end
    endtask

    task automatic compare_all();
        logic [OUT_W-1:0] el, er;
        el = (q_l.size() > 0) ? q_l[0] : '0;
        er = (q_r.size() > 0) ? q_r[0] : '0;
        check_eq("out_valid", 32'(bus.out_valid), 32'(q_l.size() > 0));
        check_eq("out_l", 32'(bus.out_l), 32'(el));
        check_eq("out_r", 32'(bus.out_r), 32'(er));
        check_eq("frame_err", 32'(frame_err), 32'(err_m));
        check_eq("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m));
    endtask

    task automatic step(input logic v, input int ch, input logic [IN_W-1:0] d, input logic [1:0] pan);
        bus.in_valid = v;
        bus.in_ch    = CH_W'(ch);
        bus.in_data  = d;
        bus.in_pan   = pan;
        model_edge(v, ch, d, pan);
        @(posedge MCLK);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 0, 9'h000, 2'b00);
    endtask

    task automatic frame(input logic [IN_W-1:0] d0, input logic [1:0] p0,
                         input logic [IN_W-1:0] dn, input logic [1:0] pn);
        step(1'b1, 0, d0, p0);
        for (int c = 1; c < NUM_CH; c++) step(1'b1, c, dn, pn);
    endtask

    initial begin
        logic v;
        int   ch;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.in_data   = '0;
        bus.in_pan    = 2'b00;
        bus.out_ready = 1'b1;
        sat_en        = 1'b1;
        model_reset();
        #3;
        check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_l", 32'(bus.out_l), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovf", 32'(ovf_cnt), 32'd0);
        @(posedge MCLK);
        #3;
        IC = 1'b1;
        idle();

        // Full-scale positive, saturating then wrapping.
        frame(9'h1FF, 2'b11, 9'h1FF, 2'b11);
        check_eq("max_sat_l", 32'(bus.out_l), 32'h7FFF);
        check_eq("max_sat_r", 32'(bus.out_r), 32'h7FFF);
        idle();
        sat_en = 1'b0;
        frame(9'h1FF, 2'b11, 9'h1FF, 2'b11);
        check_eq("max_wrap_l", 32'(bus.out_l), 32'hBF40);
        idle();
        sat_en = 1'b1;
        frame(9'h000, 2'b11, 9'h000, 2'b11);
        check_eq("min_sat_r", 32'(bus.out_r), 32'h8000);
        idle();
        frame(9'h100, 2'b11, 9'h100, 2'b11);
        check_eq("silence_v", 32'(bus.out_valid), 32'd1);
        check_eq("silence_l", 32'(bus.out_l), 32'd0);
        idle();
        frame(9'h180, 2'b10, 9'h100, 2'b11);
        check_eq("panl_l", 32'(bus.out_l), 32'h1000);
        check_eq("panl_r", 32'(bus.out_r), 32'h0000);
        idle();
        frame(9'h180, 2'b01, 9'h100, 2'b11);
        check_eq("panr_l", 32'(bus.out_l), 32'h0000);
        check_eq("panr_r", 32'(bus.out_r), 32'h1000);
        idle();

        // Sequence violation, recovery, and a stray channel while idle.
        step(1'b1, 0, 9'h1F0, 2'b11);
        step(1'b1, 1, 9'h1F0, 2'b11);
        step(1'b1, 3, 9'h1F0, 2'b11);
        check_eq("seq_err", 32'(frame_err), 32'd1);
        idle();
        check_eq("seq_err_pulse", 32'(frame_err), 32'd0);
        check_eq("seq_no_out", 32'(bus.out_valid), 32'd0);
        frame(9'h120, 2'b11, 9'h0E0, 2'b10);
        idle();
        step(1'b1, 2, 9'h1FF, 2'b11);
        check_eq("stray_err", 32'(frame_err), 32'd1);
        idle();

        // Overflow with a stalled consumer, then drain in order.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) frame(9'(9'h100 + k * 16), 2'b11, 9'(9'h104 + k), 2'b10);
        check_eq("ovf_two", 32'(ovf_cnt), 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) idle();
        check_eq("drained", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset mid-frame with two entries held.
        bus.out_ready = 1'b0;
        frame(9'h140, 2'b11, 9'h101, 2'b11);
        frame(9'h0C0, 2'b11, 9'h0FF, 2'b01);
        step(1'b1, 0, 9'h150, 2'b11);
        step(1'b1, 1, 9'h150, 2'b11);
        bus.in_valid = 1'b0;
        #2;
        IC = 1'b0;
        #1;
        check_eq("async_valid", 32'(bus.out_valid), 32'd0);
        check_eq("async_ovf", 32'(ovf_cnt), 32'd0);
        model_reset();
        @(posedge MCLK);
        #3;
        IC = 1'b1;
        bus.out_ready = 1'b1;
        step(1'b1, 1, 9'h1FF, 2'b11);
        check_eq("post_rst_err", 32'(frame_err), 32'd1);
        for (int c = 2; c < NUM_CH; c++) step(1'b1, c, 9'h1FF, 2'b11);
        check_eq("post_rst_noout", 32'(bus.out_valid), 32'd0);

        // Randomized traffic with bursts of consumer stall.
        for (int n = 0; n < 4000; n++) begin
            if (((n / 400) % 2) == 1) bus.out_ready = ($urandom_range(0, 7) == 0);
            else                      bus.out_ready = ($urandom_range(0, 3) != 0);
            sat_en = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 9) < 8);
            ch = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, NUM_CH - 1)) : got_m;
            step(v, ch, 9'($urandom), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
